// File: rtl/sc64_pkg.sv
// Shared definitions for the N64-facing config/command register window.
package sc64;

  typedef enum logic [1:0] {
    R_N64_SCR   = 2'd0,
    R_N64_DATA0 = 2'd1,
    R_N64_DATA1 = 2'd2,
    R_N64_CMD   = 2'd3
  } n64_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_BUSY = 2'd2
  } cmd_state_e;

  localparam logic [31:0] VERSION_DEF = 32'h5343_7632;

  localparam int SCR_READY_BIT = 31;
  localparam int SCR_BUSY_BIT  = 30;
  localparam int SCR_ERROR_BIT = 28;

endpackage

// File: rtl/n64_half_assembler.sv
// Pairs high/low 16-bit N64 writes into one 32-bit commit; a low half with no
// preceding high half produces no commit.
module n64_half_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        wr_stb,
  input  logic        lo_half,
  input  logic [15:0] wdata,
  output logic        commit,
  output logic [31:0] word
);

  logic [15:0] hi_hold_q, hi_hold_d;
  logic        hi_valid_q, hi_valid_d;

  always_comb begin
    hi_hold_d  = hi_hold_q;
    hi_valid_d = hi_valid_q;
    if (wr_stb && !lo_half) begin
      hi_hold_d  = wdata;
      hi_valid_d = 1'b1;
    end else if (wr_stb && lo_half) begin
      hi_valid_d = 1'b0;
    end
    if (clr) hi_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_hold_q  <= '0;
      hi_valid_q <= 1'b0;
    end else begin
      hi_hold_q  <= hi_hold_d;
      hi_valid_q <= hi_valid_d;
    end
  end

  assign commit = wr_stb && lo_half && hi_valid_q;
  assign word   = {hi_hold_q, wdata};

endmodule

// File: rtl/n64_cfg_responder.sv
// N64-side config window: half-word access assembly, DATA0/DATA1 mailbox,
// command strobe to the CPU and tear-free 32-bit status/version reads.
module n64_cfg_responder
  import sc64::*;
#(
  parameter logic [31:0] VERSION = VERSION_DEF,
  parameter int          CMD_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             n64_soft_reset,
  input  logic             bus_request,
  input  logic             bus_write,
  input  logic [2:0]       bus_address,
  input  logic [15:0]      bus_wdata,
  output logic             bus_ack,
  output logic [15:0]      bus_rdata,
  input  logic             cpu_ready,
  input  logic             cpu_busy,
  input  logic             cmd_error,
  input  logic [1:0]       cpu_data_write,
  input  logic [31:0]      cpu_wdata,
  output logic             cmd_request,
  output logic [CMD_W-1:0] cmd,
  output logic [31:0]      data0,
  output logic [31:0]      data1
);

  cmd_state_e       state_q, state_d;
  logic             bus_ack_q, bus_ack_d;
  logic [15:0]      bus_rdata_q, bus_rdata_d;
  logic [31:0]      rd_latch_q, rd_latch_d;
  logic [31:0]      data0_q, data0_d, data1_q, data1_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;

  logic        commit, cmd_pending, busy_n64;
  logic [31:0] word, rd_word;
  n64_reg_e    reg_sel;

  assign reg_sel     = n64_reg_e'(bus_address[2:1]);
  assign cmd_pending = (state_q != ST_IDLE);
  assign busy_n64    = cpu_busy | cmd_pending;

  n64_half_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .clr     (n64_soft_reset),
    .wr_stb  (bus_request & bus_write),
    .lo_half (bus_address[0]),
    .wdata   (bus_wdata),
    .commit  (commit),
    .word    (word)
  );

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      R_N64_SCR: begin
        rd_word[SCR_READY_BIT] = cpu_ready;
        rd_word[SCR_BUSY_BIT]  = busy_n64;
        rd_word[SCR_ERROR_BIT] = cmd_error;
      end
      R_N64_DATA0: rd_word = data0_q;
      R_N64_DATA1: rd_word = data1_q;
      default:     rd_word = VERSION;
    endcase
  end

  always_comb begin
    bus_ack_d   = bus_request;
    bus_rdata_d = '0;
    rd_latch_d  = rd_latch_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    cmd_d       = cmd_q;
    state_d     = state_q;

    // Low half replays the snapshot taken by the high half: atomic 32-bit read.
    if (bus_request && !bus_write) begin
      if (!bus_address[0]) begin
        rd_latch_d  = rd_word;
        bus_rdata_d = rd_word[31:16];
      end else begin
        bus_rdata_d = rd_latch_q[15:0];
      end
    end

    if (commit && !busy_n64) begin
      case (reg_sel)
        R_N64_DATA0: data0_d = word;
        R_N64_DATA1: data1_d = word;
        default: ;
      endcase
    end
    if (cpu_data_write[0]) data0_d = cpu_wdata;
    if (cpu_data_write[1]) data1_d = cpu_wdata;

    // REQ is the strobe cycle; pending covers the gap until cpu_busy rises.
    case (state_q)
      ST_IDLE:
        if (commit && !busy_n64 && reg_sel == R_N64_CMD) begin
          cmd_d   = word[CMD_W-1:0];
          state_d = ST_REQ;
        end
      ST_REQ:       state_d = cpu_busy ? ST_IDLE : ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (cpu_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (n64_soft_reset) begin
      cmd_d   = cmd_q;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bus_ack_q   <= 1'b0;
      bus_rdata_q <= '0;
      rd_latch_q  <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      cmd_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_ack_q   <= bus_ack_d;
      bus_rdata_q <= bus_rdata_d;
      rd_latch_q  <= rd_latch_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      cmd_q       <= cmd_d;
    end
  end

  assign bus_ack     = bus_ack_q;
  assign bus_rdata   = bus_rdata_q;
  assign cmd_request = (state_q == ST_REQ);
  assign cmd         = cmd_q;
  assign data0       = data0_q;
  assign data1       = data1_q;

endmodule

// File: tb/tb_n64_cfg_responder.sv
// Directed bench for n64_cfg_responder with a register-level reference model.
module tb_n64_cfg_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        n64_soft_reset = 1'b0;
  logic        bus_request = 1'b0;
  logic        bus_write = 1'b0;
  logic [2:0]  bus_address = '0;
  logic [15:0] bus_wdata = '0;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        cpu_ready = 1'b1;
  logic        cpu_busy = 1'b0;
  logic        cmd_error = 1'b0;
  logic [1:0]  cpu_data_write = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cmd_request;
  logic [7:0]  cmd;
  logic [31:0] data0, data1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_req   = 0;

  n64_cfg_responder dut (
    .clk(clk), .reset(reset), .n64_soft_reset(n64_soft_reset),
    .bus_request(bus_request), .bus_write(bus_write), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .cmd_error(cmd_error),
    .cpu_data_write(cpu_data_write), .cpu_wdata(cpu_wdata),
    .cmd_request(cmd_request), .cmd(cmd), .data0(data0), .data1(data1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register-level view of what the N64 and CPU should see.
  logic        m_ack = 0, m_req = 0, m_hiv = 0, m_pend = 0;
  logic [15:0] m_rdata = 0, m_hold = 0;
  logic [31:0] m_snap = 0, m_d0 = 0, m_d1 = 0;
  logic [7:0]  m_cmd = 0;

  function automatic logic [31:0] regval(input logic [1:0] r, input logic busy);
    case (r)
      2'd0:    return {cpu_ready, busy, 1'b0, cmd_error, 28'd0};
      2'd1:    return m_d0;
      2'd2:    return m_d1;
      default: return 32'h5343_7632;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    logic        busy, commit, req_n;
    logic [1:0]  r;
    logic [31:0] w;
    if (reset) begin
      m_ack = 0; m_req = 0; m_hiv = 0; m_pend = 0;
      m_rdata = 0; m_hold = 0; m_snap = 0; m_d0 = 0; m_d1 = 0; m_cmd = 0;
    end else begin
      busy   = cpu_busy | m_pend;
      r      = bus_address[2:1];
      commit = bus_request & bus_write & bus_address[0] & m_hiv;
      w      = {m_hold, bus_wdata};
      req_n  = 0;
      m_ack   = bus_request;
      m_rdata = 0;
      if (bus_request && !bus_write) begin
        if (!bus_address[0]) begin
          m_snap  = regval(r, busy);
          m_rdata = m_snap[31:16];
        end else m_rdata = m_snap[15:0];
      end
      if (bus_request && bus_write) begin
        if (!bus_address[0]) begin m_hold = bus_wdata; m_hiv = 1; end
        else m_hiv = 0;
      end
      if (n64_soft_reset) m_hiv = 0;
      if (commit && !busy) begin
        if (r == 2'd1) m_d0 = w;
        if (r == 2'd2) m_d1 = w;
        if (r == 2'd3 && !n64_soft_reset) begin m_cmd = w[7:0]; req_n = 1; end
      end
      if (cpu_data_write[0]) m_d0 = cpu_wdata;
      if (cpu_data_write[1]) m_d1 = cpu_wdata;
      if (n64_soft_reset) m_pend = 0;
      else if (req_n)     m_pend = 1;
      else if (cpu_busy)  m_pend = 0;
      m_req = req_n;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_ack",   {31'd0, bus_ack},     {31'd0, m_ack});
      chk("m_rdata", {16'd0, bus_rdata},   {16'd0, m_rdata});
      chk("m_cmdreq",{31'd0, cmd_request}, {31'd0, m_req});
      chk("m_cmd",   {24'd0, cmd},         {24'd0, m_cmd});
      chk("m_data0", data0, m_d0);
      chk("m_data1", data1, m_d1);
      if (cmd_request) n_req++;
    end
  end

  // Called between edges; request is sampled at the next posedge, ack checked after it.
  task automatic acc(input logic wr, input logic [2:0] a, input logic [15:0] wd,
                     output logic [15:0] rd);
    bus_request = 1; bus_write = wr; bus_address = a; bus_wdata = wd;
    @(posedge clk); #1;
    bus_request = 0; bus_write = 0; cpu_data_write = 0;
    @(negedge clk);
    chk("ack_latency", {31'd0, bus_ack}, 32'd1);
    rd = bus_rdata;
  endtask

  task automatic cpu_wr(input logic [1:0] m, input logic [31:0] d);
    cpu_data_write = m; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_data_write = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] rd;
    #12 reset = 0;
    @(negedge clk);
    chk("rst_ack",   {31'd0, bus_ack}, 32'd0);
    chk("rst_rdata", {16'd0, bus_rdata}, 32'd0);
    chk("rst_cmdreq",{31'd0, cmd_request}, 32'd0);
    chk("rst_cmd",   {24'd0, cmd}, 32'd0);
    chk("rst_data0", data0, 32'd0);
    chk("rst_data1", data1, 32'd0);

    acc(0, 3'd0, 0, rd); chk("scr_hi", {16'd0, rd}, 32'h8000);
    acc(0, 3'd1, 0, rd); chk("scr_lo", {16'd0, rd}, 32'h0000);

    acc(1, 3'd3, 16'h9999, rd); chk("lo_only_drop", data0, 32'd0);
    acc(1, 3'd2, 16'h1234, rd);
    acc(1, 3'd3, 16'h5678, rd); chk("data0_wr", data0, 32'h1234_5678);

    acc(1, 3'd6, 16'h0000, rd);
    acc(1, 3'd7, 16'h0042, rd);
    chk("cmd_val", {24'd0, cmd}, 32'h42);
    chk("cmd_strobe", {31'd0, cmd_request}, 32'd1);
    acc(0, 3'd0, 0, rd); chk("busy_req_cyc", {16'd0, rd}, 32'hC000);
    acc(0, 3'd0, 0, rd); chk("busy_gap_cyc", {16'd0, rd}, 32'hC000);
    cpu_busy = 1;
    acc(0, 3'd0, 0, rd); chk("busy_cpu", {16'd0, rd}, 32'hC000);
    acc(0, 3'd1, 0, rd); chk("busy_lo", {16'd0, rd}, 32'h0000);
    acc(1, 3'd6, 16'h0000, rd);
    acc(1, 3'd7, 16'h0055, rd);
    acc(1, 3'd2, 16'hFFFF, rd);
    acc(1, 3'd3, 16'hFFFF, rd);
    chk("req_count", n_req, 1);
    chk("cmd_kept", {24'd0, cmd}, 32'h42);
    chk("data0_busy_drop", data0, 32'h1234_5678);
    cpu_busy = 0;

    acc(0, 3'd6, 0, rd); chk("ver_hi", {16'd0, rd}, 32'h5343);
    cpu_wr(2'b01, 32'hDEAD_BEEF);
    acc(0, 3'd7, 0, rd); chk("ver_lo", {16'd0, rd}, 32'h7632);
    chk("cpu_data0", data0, 32'hDEAD_BEEF);
    acc(0, 3'd2, 0, rd); chk("d0_snap_hi", {16'd0, rd}, 32'hDEAD);
    cpu_wr(2'b01, 32'h1111_2222);
    acc(0, 3'd3, 0, rd); chk("d0_snap_lo", {16'd0, rd}, 32'hBEEF);

    acc(0, 3'd0, 0, rd); chk("scr_idle", {16'd0, rd}, 32'h8000);
    cpu_busy = 1; cmd_error = 1;
    acc(0, 3'd1, 0, rd); chk("scr_snap_lo", {16'd0, rd}, 32'h0000);
    acc(0, 3'd0, 0, rd); chk("scr_busy_err", {16'd0, rd}, 32'hD000);
    cpu_busy = 0; cmd_error = 0;

    acc(1, 3'd4, 16'hCAFE, rd);
    acc(1, 3'd5, 16'hF00D, rd); chk("data1_wr", data1, 32'hCAFE_F00D);
    acc(1, 3'd4, 16'hAAAA, rd);
    cpu_data_write = 2'b10; cpu_wdata = 32'h5555_5555;
    acc(1, 3'd5, 16'hAAAA, rd); chk("cpu_wins", data1, 32'h5555_5555);

    acc(1, 3'd2, 16'h7777, rd);
    n64_soft_reset = 1;
    @(posedge clk); #1 n64_soft_reset = 0;
    @(negedge clk);
    acc(1, 3'd3, 16'h8888, rd); chk("soft_rst_drop", data0, 32'h1111_2222);
    acc(1, 3'd2, 16'h0BAD, rd);
    acc(1, 3'd3, 16'h0001, rd); chk("post_soft_wr", data0, 32'h0BAD_0001);

    bus_request = 1; bus_write = 0; bus_address = 3'd0;
    @(posedge clk); #1 bus_request = 0;
    chk("ack_before_rst", {31'd0, bus_ack}, 32'd1);
    reset = 1;
    #1;
    chk("rst_mid_ack",   {31'd0, bus_ack}, 32'd0);
    chk("rst_mid_rdata", {16'd0, bus_rdata}, 32'd0);
    chk("rst_mid_data0", data0, 32'd0);
    chk("rst_mid_data1", data1, 32'd0);
    chk("rst_mid_cmd",   {24'd0, cmd}, 32'd0);
    #1 reset = 0;
    @(negedge clk);
    acc(0, 3'd0, 0, rd); chk("scr_after_rst", {16'd0, rd}, 32'h8000);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    n_fail++;
    $display("FAIL timeout: bench did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/n64_cfg_responder.md
Name: n64_cfg_responder

Overview:
- N64-side responder for the configuration/command register window; the opposite end of the CPU config register block.
- The N64 issues 16-bit half-word accesses. This block assembles them into 32-bit DATA0/DATA1/COMMAND writes, owns the DATA0/DATA1 mailbox registers and raises cmd_request to the CPU.
- Presents CPU status (ready/busy/error) and the firmware version to the N64 as tear-free 32-bit reads.
- Sits between the N64 PI bus decoder and the config interface.

Parameters:
- VERSION, 32'h5343_7632, value returned by the VERSION register.
- CMD_W, 8, width of the command byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- n64_soft_reset  in  1  N64 soft reset pulse, synchronous
- bus_request  in  1  one-cycle access strobe from the PI decoder
- bus_write  in  1  1 = write, 0 = read, qualified by bus_request
- bus_address  in  3  half-word index: [2:1] register, [0] 0 = high half, 1 = low half
- bus_wdata  in  16  write half-word
- bus_ack  out  1  access complete
- bus_rdata  out  16  read half-word, valid while bus_ack = 1, otherwise 0
- cpu_ready  in  1  CPU firmware ready
- cpu_busy  in  1  CPU processing a command
- cmd_error  in  1  last command failed
- cpu_data_write  in  2  CPU write strobes for DATA0/DATA1
- cpu_wdata  in  32  CPU write data
- cmd_request  out  1  one-cycle command strobe to the CPU
- cmd  out  CMD_W  latched command byte
- data0  out  32  mailbox word 0
- data1  out  32  mailbox word 1

Behaviour:
- Register map (bus_address[2:1]): 0 = SCR (read-only), 1 = DATA0, 2 = DATA1, 3 = COMMAND/VERSION. Writes to register 3 go to COMMAND; reads of register 3 return VERSION.
- SCR value: {cpu_ready, busy_n64, 1'b0, cmd_error, 28'd0}.
  - busy_n64 = cpu_busy | cmd_pending.
- Reset values:
  - bus_ack = 0, bus_rdata = 0, cmd_request = 0.
  - cmd = 0, data0 = 0, data1 = 0.
  - hi_hold = 0, hi_valid = 0, rd_latch = 0, cmd_pending = 0.
- Ack timing: bus_ack goes high exactly one cycle after bus_request for both reads and writes, then returns low.
  - At most one request is in flight; a request arriving in the ack cycle is accepted normally.
- Read, high half: capture the full 32-bit register value into rd_latch and return bits [31:16].
- Read, low half: return rd_latch[15:0].
  - Low-half reads never re-sample, so the two halves form one atomic snapshot.
- Write, high half: store bus_wdata in hi_hold and set hi_valid. No register changes.
- Write, low half: if hi_valid = 1, commit {hi_hold, bus_wdata} to the target register, then clear hi_valid.
  - If hi_valid = 0, the write is acked and dropped.
- Commit to DATA0/DATA1: ignored while busy_n64 = 1, but hi_valid is still cleared.
- Commit to COMMAND while busy_n64 = 0:
  - cmd <= word[CMD_W-1:0];
  - cmd_request = 1 for exactly the cycle after the commit;
  - cmd_pending is set.
- Commit to COMMAND while busy_n64 = 1: dropped, no strobe.
- Pending handshake: cmd_pending clears on the first cycle cpu_busy = 1.
  - This covers the one-cycle gap before the CPU's busy flag rises.
  - If cpu_busy never rises, cmd_pending holds until reset or n64_soft_reset.
- State machine: IDLE -> (COMMAND commit accepted) REQ -> (next cycle) WAIT_BUSY -> (cpu_busy = 1) IDLE.
  - n64_soft_reset returns the machine to IDLE from any state.
- CPU writes: cpu_data_write[i] loads data_i from cpu_wdata in the same cycle and is always honoured.
  - If a CPU write and an N64 commit hit the same DATA register in the same cycle, the CPU write wins.
- n64_soft_reset clears hi_valid and cmd_pending.
  - data0, data1 and cmd are retained.
  - An access in flight still receives its ack.
- Asynchronous reset mid-access: bus_ack drops immediately and the access is lost.

Decomposition:
- Shared package sc64 holds:
  - the register-index enum (R_N64_SCR, R_N64_DATA0, R_N64_DATA1, R_N64_CMD);
  - the VERSION constant;
  - the SCR bit positions.
- Sub-module n64_half_assembler owns hi_hold/hi_valid and produces a commit strobe plus the 32-bit word. It is reused by other N64 register windows.

Test Plan:
- Reset, then read half-words 0 and 1 with cpu_ready=1, cpu_busy=0, cmd_error=0 -> reads 16'h8000, then 16'h0000; each ack arrives 1 cycle after request.
- Write DATA0 as 16'h1234 (high) then 16'h5678 (low) -> data0 = 32'h1234_5678 after the low-half ack; a low-half write alone leaves data0 unchanged.
- Write COMMAND as 16'h0000 then 16'h0042 -> cmd = 8'h42 and a single one-cycle cmd_request. cpu_busy rises 1 cycle later; SCR reads busy = 1 continuously, including the gap cycle. A second COMMAND write while busy produces no strobe.
- Read VERSION high half, drive cpu_data_write unrelatedly, then read the low half -> 16'h5343 then 16'h7632. Read SCR high half, toggle cpu_busy, then read the low half -> low half comes from the snapshot.
- Same-cycle N64 DATA1 commit of 32'hAAAA_AAAA and cpu_data_write[1] with 32'h5555_5555 -> data1 = 32'h5555_5555.
- Write a high half, pulse n64_soft_reset, then write a low half -> no commit. Separately, pulse reset during the ack cycle -> bus_ack = 0 immediately and all outputs return to reset values.
